// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the front-panel button conditioning path.
//   deb_state_t          : per-channel debounce FSM state
//   CLK_HZ               : system clock frequency (125 MHz)
//   DEBOUNCE_MS_DEFAULT  : default debounce window in milliseconds
//   ms_to_cycles()       : converts a window in ms to a count of CLK_HZ cycles
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } deb_state_t;

    localparam int unsigned CLK_HZ              = 125_000_000;
    localparam int unsigned DEBOUNCE_MS_DEFAULT = 10;

    // 10 ms at 125 MHz -> 1_250_000 cycles.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage : btn_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One pushbutton/switch channel: SYNC_STAGES-deep synchroniser followed by a
// two-state debounce FSM that accepts a new level only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current output level.
//   i_clk    : system clock
//   i_rst    : asynchronous, active-high reset
//   i_raw    : raw asynchronous pad input (may bounce)
//   o_level  : debounced level
//   o_fall   : one-cycle strobe on accepted 1->0 (press)
//   o_rise   : one-cycle strobe on accepted 0->1 (release)
//   o_busy   : high while a candidate change is being qualified
// SYNC_STAGES and DEBOUNCE_CYCLES must both be at least 2.
// -----------------------------------------------------------------------------
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS_DEFAULT),
    parameter logic        RST_LEVEL       = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_fall,
    output logic o_rise,
    output logic o_busy
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_out;

    deb_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_fall;
    logic                   r_rise;
    logic                   r_busy;

    // Plain flop chain, nothing between stages, so metastability has a full
    // cycle per stage to resolve. Reset to the idle level so a reset never
    // presents a false "pressed" sample to the FSM.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours and the chain shifts by one stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RST_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // The counter holds the number of consecutive differing samples already
    // seen; the sample that makes it DEBOUNCE_CYCLES is the one that commits.
    // Any sample matching the current level abandons the candidate.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_level <= RST_LEVEL;
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            r_rise <= 1'b0;
            unique case (r_state)
                STABLE: begin
                    if (w_sync_out != r_level) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= QUALIFY;
                        r_busy  <= 1'b1;
                    end
                end
                QUALIFY: begin
                    if (w_sync_out == r_level) begin
                        r_cnt   <= '0;
                        r_state <= STABLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_level <= w_sync_out;
                        r_cnt   <= '0;
                        r_state <= STABLE;
                        r_busy  <= 1'b0;
                        r_fall  <= ~w_sync_out;
                        r_rise  <= w_sync_out;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= STABLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;
    assign o_rise  = r_rise;
    assign o_busy  = r_busy;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Front-end conditioning for the front-panel buttons and adjust-mode switch
// feeding the DDS frequency-control FSMs. Each channel is synchronised and
// debounced independently; simultaneous presses are passed through unchanged.
// Channel map: bit 0 increase, bit 1 decrease, bit 2 adjust-mode switch.
// Inputs are active-low (idle = 1).
//   i_clk      : 125 MHz system clock
//   i_rst      : asynchronous, active-high reset
//   i_btn_raw  : raw pad inputs [N_BTN]
//   o_level    : debounced levels [N_BTN]
//   o_fall     : one-cycle press strobes [N_BTN]
//   o_rise     : one-cycle release strobes [N_BTN]
//   o_busy     : per-channel "qualifying a change" flags [N_BTN]
// -----------------------------------------------------------------------------
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned       N_BTN           = 3,
    parameter int unsigned       SYNC_STAGES     = 2,
    parameter int unsigned       DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS_DEFAULT),
    parameter logic [N_BTN-1:0]  RST_LEVEL       = {N_BTN{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_fall,
    output logic [N_BTN-1:0] o_rise,
    output logic [N_BTN-1:0] o_busy
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_LEVEL       (RST_LEVEL[g])
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (i_btn_raw[g]),
            .o_level (o_level[g]),
            .o_fall  (o_fall[g]),
            .o_rise  (o_rise[g]),
            .o_busy  (o_busy[g])
        );
    end

endmodule : button_conditioner

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end conditioning for the front-panel pushbuttons and the adjust-mode switch that drive the DDS frequency-control FSMs (increase, decrease, coarse/fine select).
- Synchronises each raw asynchronous input into the 125 MHz domain and debounces it with a per-channel counter.
- Emits clean levels plus one-cycle press and release strobes.
- Buttons are active-low: idle/released = 1. The downstream FSMs rely on "both buttons = 1" to mean released, so this block must never emit spurious 0s.

Parameters:
- N_BTN, 3, number of independent channels (bit 0 increase, bit 1 decrease, bit 2 adjust-mode switch).
- SYNC_STAGES, 2, synchroniser flops per channel; minimum 2.
- DEBOUNCE_CYCLES, 1250000, consecutive stable samples required to accept a new level (10 ms at 125 MHz); minimum 2.
- RST_LEVEL, {N_BTN{1'b1}}, per-channel reset value of the synchroniser and output level.

Ports:
- i_clk  in  1  system clock, 125 MHz.
- i_rst  in  1  asynchronous, active-high reset.
- i_btn_raw  in  N_BTN  raw pad inputs, asynchronous, may bounce.
- o_level  out  N_BTN  debounced level per channel.
- o_fall  out  N_BTN  one-cycle strobe on accepted 1->0 (press).
- o_rise  out  N_BTN  one-cycle strobe on accepted 0->1 (release).
- o_busy  out  N_BTN  high while a channel is qualifying a candidate change.

Behaviour:
- Reset (asynchronous, active-high; the clock and reset are fixed as stated here):
  - While i_rst = 1: all synchroniser flops = RST_LEVEL; o_level = RST_LEVEL; o_fall, o_rise, o_busy = 0; counters = 0; state = STABLE.
  - Reset takes effect immediately with no clock edge; outputs are glitch-free on release.
- Channels are fully independent; no cross-channel interlock. Both buttons pressed at once is passed through unchanged.
- Synchroniser:
  - s[i] = output of the last of SYNC_STAGES flops.
  - No logic between the stages.
- Per-channel FSM, 2 states:
  - STABLE, when s != o_level: cnt <= 1; go to QUALIFY; o_busy = 1.
  - QUALIFY, when s == o_level: cnt <= 0; return to STABLE. This is a bounce and produces no output change.
  - QUALIFY, when s != o_level and cnt == DEBOUNCE_CYCLES-1: o_level <= s; cnt <= 0; go to STABLE; pulse o_fall or o_rise according to the new level.
  - QUALIFY, otherwise: cnt <= cnt + 1.
- Latency:
  - If the raw input settles between edges 0 and 1, o_level changes at edge SYNC_STAGES + DEBOUNCE_CYCLES.
  - The strobe is registered and high for exactly that one cycle, coincident with the new o_level.
- Counter width: $clog2(DEBOUNCE_CYCLES).
  - The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- A pulse of DEBOUNCE_CYCLES-1 samples or fewer never reaches o_level.
- o_fall and o_rise are never simultaneously high on one channel.
- Reset mid-qualification: the count is discarded, and the full DEBOUNCE_CYCLES is required again after reset release.
- o_busy[i] = (state == QUALIFY). It is registered and reflects the current state.

Decomposition:
- Shared package btn_pkg:
  - typedef enum logic {STABLE, QUALIFY} deb_state_t.
  - localparam CLK_HZ = 125_000_000.
  - localparam DEBOUNCE_MS_DEFAULT = 10.
  - function ms_to_cycles().
- One sub-module, debounce_channel: one synchroniser plus counter FSM plus strobes, with scalar ports.
- button_conditioner is a generate loop of N_BTN debounce_channel instances with per-bit RST_LEVEL.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 8 and SYNC_STAGES = 2.
1. Async reset: i_rst = 1 at a non-edge time while o_level = 3'b010 -> o_level = 3'b111 and strobes 0 before the next edge. After release, i_btn_raw = 3'b111 keeps outputs unchanged with no strobes.
2. Clean press: i_btn_raw[0] 1->0 between edges 0 and 1, held for 20 cycles -> o_level[0] = 0 at edge 10; o_fall[0] = 1 only during cycle 10; o_busy[0] high for edges 3-9.
3. Bounce: i_btn_raw[1] toggles every 3 cycles for 30 cycles, then holds 0 -> no o_level or strobe change during bouncing; o_level[1] falls 10 edges after the last toggle.
4. Glitch rejection: i_btn_raw[0] low for exactly 7 cycles -> o_level stays 1; no o_fall or o_rise. The same input held for 8 cycles -> accepted at edge 10.
5. Simultaneous: channels 0 and 1 pressed on the same cycle and released on the same cycle -> o_fall[1:0] = 2'b11 on one edge, later o_rise[1:0] = 2'b11 on one edge; o_level[1:0] returns to 2'b11.
6. Reset mid-count: channel 2 held low; i_rst pulsed after 5 qualifying cycles -> o_level[2] = 1 throughout; the change is accepted 10 edges after reset release.
